// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM stage: word RAM with programmable wait
// states, registered read data, one-cycle ready pulse and a stall to the sequencer.
module data_mem_resp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_stage,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              stall,
    output logic              err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                op_wr_q, op_wr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic accept;
    logic conflict;
    logic do_access;
    logic mem_we;

    assign accept    = (state_q == IDLE) && mem_stage && (read ^ write);
    assign conflict  = (state_q == IDLE) && mem_stage && read && write;
    assign do_access = (state_q == BUSY) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // RAM is never cleared; reset only blocks a write landing on its edge
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end else if (conflict) begin
                    state_d = DRAIN;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP:  state_d = DRAIN;
            DRAIN: begin
                if (!mem_stage) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_wr_d = op_wr_q;
        rdata_d = rdata_q;
        ready_d = do_access;
        err_d   = conflict;
        mem_we  = do_access && op_wr_q;
        if (accept) begin
            cnt_d   = CNT_W'(WAIT_CYC);
            addr_d  = addr;
            wdata_d = wdata;
            op_wr_d = write;
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (do_access && !op_wr_q) begin
            rdata_d = mem_q[addr_q];
        end
    end

    assign stall = accept || (state_q == BUSY);
    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: one instance with one wait state and
// one with none, both fed the same request stream.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_stage = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata0, rdata1;
    logic        ready0, ready1, stall0, stall1, err0, err1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] shadow0 [256];
    logic [15:0] shadow1 [256];
    logic [15:0] lastrd0 = '0;
    logic [15:0] lastrd1 = '0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    data_mem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(1)) u_dut0 (
        .clk(clk), .reset(reset), .mem_stage(mem_stage),
        .read(read), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .stall(stall0), .err(err0)
    );

    data_mem_resp #(.DATA_W(16), .ADDR_W(8), .WAIT_CYC(0)) u_dut1 (
        .clk(clk), .reset(reset), .mem_stage(mem_stage),
        .read(read), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .stall(stall1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Completion monitor: every ready pops one scoreboard entry
    always @(negedge clk) begin
        if (ready0) begin
            if (q0.size() == 0) check("ready0_unexpected", 1, 0);
            else check("rdata0", rdata0, q0.pop_front());
        end
        if (ready1) begin
            if (q1.size() == 0) check("ready1_unexpected", 1, 0);
            else check("rdata1", rdata1, q1.pop_front());
        end
        if (ready0 || err0) check("err_ready0_excl", ready0 & err0, 0);
        if (ready1 || err1) check("err_ready1_excl", ready1 & err1, 0);
    end

    task automatic push_req(input bit rd, input bit wr,
                            input logic [7:0] a, input logic [15:0] d);
        if (rd && !wr) begin
            q0.push_back(shadow0[a]);
            q1.push_back(shadow1[a]);
            lastrd0 = shadow0[a];
            lastrd1 = shadow1[a];
        end else if (wr && !rd) begin
            q0.push_back(lastrd0);
            q1.push_back(lastrd1);
            shadow0[a] = d;
            shadow1[a] = d;
        end
    endtask

    // Full MEM window of hold cycles, then one cycle with mem_stage low
    task automatic req(input bit rd, input bit wr, input logic [7:0] a,
                       input logic [15:0] d, input int hold);
        bit valid;
        bit both;
        valid = rd ^ wr;
        both  = rd & wr;
        mem_stage = 1'b1;
        read  = rd;
        write = wr;
        addr  = a;
        wdata = d;
        push_req(rd, wr, a, d);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("ready0_k", ready0, valid && (k == 3));
            check("stall0_k", stall0, valid && (k < 3));
            check("err0_k", err0, both && (k == 1));
            check("ready1_k", ready1, valid && (k == 2));
            check("stall1_k", stall1, valid && (k < 2));
            check("err1_k", err1, both && (k == 1));
            @(posedge clk);
            #1;
            if (k == 0) begin
                addr  = 8'h00;
                wdata = 16'h0000;
            end
        end
        mem_stage = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check("gap_stall0", stall0, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [15:0] rd16;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_rdata0", rdata0, 0);
        check("rst_ready0", ready0, 0);
        check("rst_err0", err0, 0);
        check("rst_stall0", stall0, 0);
        check("rst_rdata1", rdata1, 0);
        @(posedge clk);
        #1;

        req(0, 1, 8'h00, 16'h1111, 4);
        req(0, 1, 8'h05, 16'h5555, 4);
        req(0, 1, 8'h40, 16'h4040, 4);

        req(0, 1, 8'h12, 16'hBEEF, 5);
        req(1, 0, 8'h12, 16'h0000, 5);
        req(1, 0, 8'h12, 16'h0000, 14);
        check("hold_rdata0", rdata0, 16'hBEEF);

        req(1, 1, 8'h05, 16'h9999, 3);
        req(1, 0, 8'h05, 16'h0000, 4);

        // Reset lands on the access edge of the one-wait instance only
        mem_stage = 1'b1;
        write = 1'b1;
        addr  = 8'h40;
        wdata = 16'h1234;
        q1.push_back(lastrd1);
        shadow1[8'h40] = 16'h1234;
        @(negedge clk);
        check("rst_mid_stall0_c0", stall0, 1);
        @(posedge clk);
        #1;
        addr  = 8'h00;
        wdata = 16'h0000;
        @(negedge clk);
        check("rst_mid_stall0_c1", stall0, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ready0_c2", ready0, 0);
        check("rst_mid_ready1_c2", ready1, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_stage = 1'b0;
        write = 1'b0;
        lastrd0 = '0;
        lastrd1 = '0;
        @(negedge clk);
        check("rst_mid_ready0_c3", ready0, 0);
        check("rst_mid_stall0_c3", stall0, 0);
        check("rst_mid_rdata0_c3", rdata0, 0);
        check("rst_mid_ready1_c3", ready1, 0);
        @(posedge clk);
        #1;
        req(1, 0, 8'h40, 16'h0000, 4);

        req(0, 1, 8'hFF, 16'hA5A5, 4);
        req(1, 0, 8'hFF, 16'h0000, 4);

        req(0, 1, 8'h30, 16'h7777, 4);
        req(1, 0, 8'h30, 16'h0000, 4);
        req(1, 0, 8'h00, 16'h0000, 4);

        for (int i = 0; i < 6; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rd16 = 16'($urandom);
            req(0, 1, ra, rd16, 4);
            req(1, 0, ra, 16'h0000, 4);
        end

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
